// File: rtl/exec_ctrl_pkg.sv
//------------------------------------------------------------------------------
// exec_ctrl_pkg
// Shared state encoding and widths for the minisys execution sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package exec_ctrl_pkg;

   localparam int RETIRE_CNT_WIDTH = 32;

   // Encodings are visible on state_o, so they are fixed explicitly.
   // ST_STEP stays reserved unless single-step support is compiled in.
   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_WAIT_IN = 3'd1,
      ST_IN_DONE = 3'd2,
      ST_SHOW    = 3'd3,
      ST_HALT    = 3'd4,
      ST_STEP    = 3'd5
   } exec_state_t;

endpackage

`default_nettype wire

// File: rtl/exec_ctrl_hold_timer.sv
//------------------------------------------------------------------------------
// hold_timer
// Loadable down-counter that times the post-LED-write hold. A load takes
// priority, an abort clears the count, and o_expire flags the last
// decrementing cycle so the sequencer can leave the hold on that cycle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hold_timer #(
   parameter int CNT_WIDTH = 24
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_load,
   input  logic [CNT_WIDTH-1:0] i_load_val,
   input  logic                 i_dec,
   input  logic                 i_abort,
   output logic                 o_expire
);

   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] r_count;

   // Count register: load beats abort beats decrement; never underflows.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_abort) begin
         r_count <= '0;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - ONE;
      end
   end

   assign o_expire = i_dec && (r_count == ONE);

endmodule

`default_nettype wire

// File: rtl/exec_ctrl.sv
//------------------------------------------------------------------------------
// exec_ctrl
// Execution sequencer for the single-cycle minisys CPU. cpu_en gates PC update,
// register write and memory/LED write. Stalls switch reads until confirm,
// optionally holds after LED writes, and freezes on halt.
// Optional feature macro: EXEC_SINGLE_STEP_EN (single-step via confirm).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter int SW_WIDTH    = 16,
   parameter int SHOW_CYCLES = 0,
   parameter int CNT_WIDTH   = 24
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        io_read,
   input  logic                        switch_ctrl,
   input  logic                        led_ctrl,
   input  logic                        halt_insn,
   input  logic                        confirm,
   input  logic                        step_mode,
   input  logic [SW_WIDTH-1:0]         switches,
   output logic                        cpu_en,
   output logic [SW_WIDTH-1:0]         in_data,
   output logic                        waiting,
   output logic [2:0]                  state_o,
   output logic [RETIRE_CNT_WIDTH-1:0] retire_cnt
);

   localparam bit                   SHOW_EN   = (SHOW_CYCLES != 0);
   localparam logic [CNT_WIDTH-1:0] SHOW_LOAD = CNT_WIDTH'(SHOW_CYCLES);

   exec_state_t                 r_state;
   exec_state_t                 w_next;
   logic [SW_WIDTH-1:0]         r_in_data;
   logic [RETIRE_CNT_WIDTH-1:0] r_retire_cnt;
   logic                        w_retire;
   logic                        w_wait;
   logic                        w_latch;
   logic                        w_load;
   logic                        w_dec;
   logic                        w_abort;
   logic                        w_expire;
   logic                        w_step_sel;
   logic                        w_sw_read;

`ifdef EXEC_SINGLE_STEP_EN
   assign w_step_sel = step_mode;
`else
   logic w_unused_step_mode;
   assign w_unused_step_mode = step_mode;
   assign w_step_sel         = 1'b0;
`endif

   assign w_sw_read = io_read && switch_ctrl;

   hold_timer #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_hold_timer (
      .i_clk      (clock),
      .i_rst_n    (reset_n),
      .i_load     (w_load),
      .i_load_val (SHOW_LOAD),
      .i_dec      (w_dec),
      .i_abort    (w_abort),
      .o_expire   (w_expire)
   );

   // Next-state and retire decision; priority is halt, then switch read, then step gate.
   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      w_wait   = 1'b0;
      w_latch  = 1'b0;
      w_load   = 1'b0;
      w_dec    = 1'b0;
      w_abort  = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            if (halt_insn) begin
               w_next = ST_HALT;
            end else if (w_sw_read) begin
               w_next = ST_WAIT_IN;
            end else if (w_step_sel) begin
               w_next = ST_STEP;
            end else begin
               w_retire = 1'b1;
               if (led_ctrl && SHOW_EN) begin
                  w_load = 1'b1;
                  w_next = ST_SHOW;
               end
            end
         end
         ST_WAIT_IN: begin
            w_wait = 1'b1;
            if (confirm) begin
               w_latch = 1'b1;
               w_next  = ST_IN_DONE;
            end
         end
         ST_IN_DONE: begin
            // The load retires here; a led_ctrl seen now is not a new LED write.
            w_retire = 1'b1;
            w_next   = ST_RUN;
         end
         ST_SHOW: begin
            w_dec   = 1'b1;
            w_abort = confirm;
            if (w_expire || confirm) begin
               w_next = ST_RUN;
            end
         end
         ST_HALT: begin
            w_wait = 1'b1;
         end
`ifdef EXEC_SINGLE_STEP_EN
         ST_STEP: begin
            w_wait = 1'b1;
            if (!confirm) begin
               w_next = step_mode ? ST_STEP : ST_RUN;
            end else if (halt_insn) begin
               w_next = ST_HALT;
            end else if (w_sw_read) begin
               w_next = ST_WAIT_IN;
            end else begin
               w_retire = 1'b1;
               if (led_ctrl && SHOW_EN) begin
                  w_load = 1'b1;
                  w_next = ST_SHOW;
               end else begin
                  w_next = step_mode ? ST_STEP : ST_RUN;
               end
            end
         end
`endif
         default: begin
            w_next = ST_RUN;
         end
      endcase
   end

   // Nothing retires and nothing waits while reset is asserted.
   assign cpu_en  = w_retire && reset_n;
   assign waiting = w_wait && reset_n;

   // State, input latch and retire counter; reset abandons any stall.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state      <= ST_RUN;
         r_in_data    <= '0;
         r_retire_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_in_data <= switches;
         end
         if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
         end
      end
   end

   assign in_data    = r_in_data;
   assign state_o    = r_state;
   assign retire_cnt = r_retire_cnt;

endmodule

`default_nettype wire
